// File: rtl/fastica_pkg.sv
// Shared definitions for the FastICA nonlinearity/accumulation block:
// default widths, FSM states and the saturating fixed-point shift.
package fastica_pkg;

    localparam int unsigned DwDefault   = 26;
    localparam int unsigned FracDefault = 16;

    // Wide enough for any DW*DW product the block is built with.
    localparam int unsigned WideW = 128;
    typedef logic signed [WideW-1:0] wide_t;

    typedef enum logic [1:0] {StIdle, StAcc, StDrain, StOut} state_e;

    function automatic wide_t sat_shr(wide_t product, int unsigned shift, int unsigned width);
        wide_t shifted;
        wide_t hi;
        wide_t lo;
        shifted = product >>> shift;
        hi      = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo      = -(wide_t'(1) <<< (width - 1));
        if (shifted > hi) begin
            shifted = hi;
        end else if (shifted < lo) begin
            shifted = lo;
        end
        return shifted;
    endfunction

    // Word position of E{z_i * g(y_j)} on the flat bus, i and j zero-based.
    function automatic int unsigned ezg_word(int unsigned i, int unsigned j);
        return i * 4 + j;
    endfunction

endpackage

// File: rtl/fastica_nonlin_acc_if.sv
// Sample/result bundle between the W*z stage, this block and the weight update.
interface fastica_nonlin_acc_if
    import fastica_pkg::*;
#(
    parameter int unsigned DW = DwDefault
);
    logic                 start;
    logic                 in_valid;
    logic signed [DW-1:0] y1, y2, y3, y4;
    logic signed [DW-1:0] z1, z2, z3, z4;
    logic                 busy;
    logic                 out_valid;
    logic                 done;
    logic [16*DW-1:0]     ezg_flat;
    logic [4*DW-1:0]      egp_flat;

    modport master (
        output start, in_valid, y1, y2, y3, y4, z1, z2, z3, z4,
        input  busy, out_valid, done, ezg_flat, egp_flat
    );

    modport slave (
        input  start, in_valid, y1, y2, y3, y4, z1, z2, z3, z4,
        output busy, out_valid, done, ezg_flat, egp_flat
    );
endinterface

// File: rtl/fastica_cube_lane.sv
// One component's y -> (y^2, y^3) two-stage pipe; stages advance only on their valid token.
module fastica_cube_lane
    import fastica_pkg::*;
#(
    parameter int unsigned DW   = DwDefault,
    parameter int unsigned FRAC = FracDefault
) (
    input  logic                 clk_acc,
    input  logic                 rstn_acc,
    input  logic                 en1,
    input  logic                 en2,
    input  logic signed [DW-1:0] y,
    output logic signed [DW-1:0] cube,
    output logic signed [DW-1:0] sq_d
);
    logic signed [DW-1:0] y_s1;
    logic signed [DW-1:0] sq_s1;
    logic signed [DW-1:0] sq_n;
    logic signed [DW-1:0] cube_n;

    always_comb begin
        sq_n   = DW'(sat_shr(wide_t'(y) * wide_t'(y), FRAC, DW));
        cube_n = DW'(sat_shr(wide_t'(sq_s1) * wide_t'(y_s1), FRAC, DW));
    end

    always_ff @(posedge clk_acc or negedge rstn_acc) begin
        if (!rstn_acc) begin
            y_s1  <= '0;
            sq_s1 <= '0;
            cube  <= '0;
            sq_d  <= '0;
        end else begin
            if (en1) begin
                y_s1  <= y;
                sq_s1 <= sq_n;
            end
            if (en2) begin
                cube <= cube_n;
                sq_d <= sq_s1;
            end
        end
    end
endmodule

// File: rtl/fastica_nonlin_acc.sv
// Batch accumulator of E{z_i*y_j^3} and E{3*y_j^2} over 2^LOG2N samples,
// with the result averaged and held on the output buses until the next start.
module fastica_nonlin_acc
    import fastica_pkg::*;
#(
    parameter int unsigned DW    = DwDefault,
    parameter int unsigned FRAC  = FracDefault,
    parameter int unsigned LOG2N = 10
) (
    input logic                 clk_acc,
    input logic                 rstn_acc,
    fastica_nonlin_acc_if.slave bus
);
    localparam int unsigned AW = DW + LOG2N + 2;
    typedef logic [LOG2N:0] cnt_t;
    localparam cnt_t LastSample = cnt_t'((1 << LOG2N) - 1);
    localparam cnt_t LastDrain  = cnt_t'(2);

    state_e               state_q;
    cnt_t                 cnt_q;
    logic                 busy_q, out_valid_q, done_q;
    logic [16*DW-1:0]     ezg_q, ezg_n;
    logic [4*DW-1:0]      egp_q, egp_n;
    logic                 accept, v1_q, v2_q;
    logic signed [DW-1:0] y_in [4];
    logic signed [DW-1:0] z_in [4];
    logic signed [DW-1:0] z_s1 [4];
    logic signed [DW-1:0] z_s2 [4];
    logic signed [DW-1:0] cube [4];
    logic signed [DW-1:0] sq_s2 [4];
    logic signed [DW-1:0] term [16];
    logic signed [AW-1:0] acc_q [16];
    logic signed [AW-1:0] gp_q [4];

    assign y_in = '{bus.y1, bus.y2, bus.y3, bus.y4};
    assign z_in = '{bus.z1, bus.z2, bus.z3, bus.z4};
    assign accept = (state_q == StAcc) && bus.in_valid;

    for (genvar j = 0; j < 4; j++) begin : g_lane
        fastica_cube_lane #(.DW(DW), .FRAC(FRAC)) u_lane (
            .clk_acc  (clk_acc),
            .rstn_acc (rstn_acc),
            .en1      (accept),
            .en2      (v1_q),
            .y        (y_in[j]),
            .cube     (cube[j]),
            .sq_d     (sq_s2[j])
        );
    end

    always_ff @(posedge clk_acc or negedge rstn_acc) begin
        if (!rstn_acc) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                z_s1[i] <= '0;
                z_s2[i] <= '0;
            end
        end else begin
            v1_q <= accept;
            v2_q <= v1_q;
            for (int i = 0; i < 4; i++) begin
                if (accept) z_s1[i] <= z_in[i];
                if (v1_q)   z_s2[i] <= z_s1[i];
            end
        end
    end

    always_comb begin
        ezg_n = '0;
        egp_n = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                term[ezg_word(i, j)] =
                    DW'(sat_shr(wide_t'(z_s2[i]) * wide_t'(cube[j]), FRAC, DW));
            end
        end
        for (int k = 0; k < 16; k++) begin
            ezg_n[k*DW +: DW] = DW'(sat_shr(wide_t'(acc_q[k]), LOG2N, DW));
        end
        for (int j = 0; j < 4; j++) begin
            egp_n[j*DW +: DW] = DW'(sat_shr(wide_t'(gp_q[j]), LOG2N, DW));
        end
    end

    always_ff @(posedge clk_acc or negedge rstn_acc) begin
        if (!rstn_acc) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ezg_q       <= '0;
            egp_q       <= '0;
            for (int k = 0; k < 16; k++) acc_q[k] <= '0;
            for (int j = 0; j < 4; j++)  gp_q[j]  <= '0;
        end else begin
            done_q <= 1'b0;
            if (v2_q) begin
                for (int k = 0; k < 16; k++) acc_q[k] <= acc_q[k] + AW'(term[k]);
                for (int j = 0; j < 4; j++) begin
                    gp_q[j] <= gp_q[j] + AW'(sq_s2[j]) + (AW'(sq_s2[j]) <<< 1);
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q     <= StAcc;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                        for (int k = 0; k < 16; k++) acc_q[k] <= '0;
                        for (int j = 0; j < 4; j++)  gp_q[j]  <= '0;
                    end
                end
                StAcc: begin
                    if (bus.in_valid) begin
                        cnt_q <= cnt_q + cnt_t'(1);
                        if (cnt_q == LastSample) begin
                            state_q <= StDrain;
                            cnt_q   <= '0;
                        end
                    end
                end
                StDrain: begin
                    cnt_q <= cnt_q + cnt_t'(1);
                    if (cnt_q == LastDrain) begin
                        state_q <= StOut;
                        busy_q  <= 1'b0;
                    end
                end
                StOut: begin
                    ezg_q       <= ezg_n;
                    egp_q       <= egp_n;
                    done_q      <= 1'b1;
                    out_valid_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.ezg_flat  = ezg_q;
    assign bus.egp_flat  = egp_q;
endmodule

// File: tb/tb_fastica_nonlin_acc.sv
// Bench for fastica_nonlin_acc with N=4: vector table of steady batches,
// scoreboard of model results popped on done, plus abort/gap/ignored-control sequences.
module tb_fastica_nonlin_acc;
    localparam int unsigned DW    = 26;
    localparam int unsigned FRAC  = 16;
    localparam int unsigned LOG2N = 2;

    typedef logic signed [DW-1:0] word_t;
    typedef struct { word_t y[4]; word_t z[4]; } samp_t;
    typedef struct { samp_t s; longint hand_ezg0; longint hand_egp0; } vec_t;
    typedef struct { longint ezg[16]; longint egp[4]; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    int   last_acc_cyc = 0;
    logic done_prev = 1'b0;
    exp_t sb_q[$];
    vec_t vecs[6];

    fastica_nonlin_acc_if #(.DW(DW)) bus ();

    fastica_nonlin_acc #(.DW(DW), .FRAC(FRAC), .LOG2N(LOG2N)) dut (
        .clk_acc  (clk),
        .rstn_acc (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint satw(input longint v);
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -(longint'(1) <<< (DW - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic exp_t model(input samp_t q[4]);
        exp_t   e;
        longint acc[16];
        longint gp[4];
        longint y, z, sq, cb;
        for (int k = 0; k < 16; k++) acc[k] = 0;
        for (int j = 0; j < 4; j++) gp[j] = 0;
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 4; j++) begin
                y = q[s].y[j];
                sq = satw((y * y) >>> FRAC);
                cb = satw((sq * y) >>> FRAC);
                gp[j] += 3 * sq;
                for (int i = 0; i < 4; i++) begin
                    z = q[s].z[i];
                    acc[i*4+j] += satw((z * cb) >>> FRAC);
                end
            end
        end
        for (int k = 0; k < 16; k++) e.ezg[k] = satw(acc[k] >>> LOG2N);
        for (int j = 0; j < 4; j++) e.egp[j] = satw(gp[j] >>> LOG2N);
        return e;
    endfunction

    function automatic samp_t mk(input longint ya, input longint yb, input longint yc,
                                 input longint yd, input longint za, input longint zb,
                                 input longint zc, input longint zd);
        samp_t s;
        s.y[0] = word_t'(ya); s.y[1] = word_t'(yb); s.y[2] = word_t'(yc); s.y[3] = word_t'(yd);
        s.z[0] = word_t'(za); s.z[1] = word_t'(zb); s.z[2] = word_t'(zc); s.z[3] = word_t'(zd);
        return s;
    endfunction

    function automatic longint ezg_w(input int k);
        return longint'($signed(bus.ezg_flat[k*DW +: DW]));
    endfunction

    function automatic longint egp_w(input int j);
        return longint'($signed(bus.egp_flat[j*DW +: DW]));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            done_cnt++;
            check("done_pulse_width", longint'(done_prev), 0);
            check("done_expected", longint'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("out_valid_with_done", longint'(bus.out_valid), 1);
                check("done_latency", longint'(cyc - last_acc_cyc), 4);
                for (int k = 0; k < 16; k++) check($sformatf("ezg[%0d]", k), ezg_w(k), e.ezg[k]);
                for (int j = 0; j < 4; j++) check($sformatf("egp[%0d]", j), egp_w(j), e.egp[j]);
            end
        end
        done_prev = bus.done;
    end

    task automatic drive(input samp_t s);
        bus.y1 = s.y[0]; bus.y2 = s.y[1]; bus.y3 = s.y[2]; bus.y4 = s.y[3];
        bus.z1 = s.z[0]; bus.z2 = s.z[1]; bus.z3 = s.z[2]; bus.z4 = s.z[3];
    endtask

    task automatic run_batch(input samp_t q[4], input int gap, input bit start_mid,
                             input bit drain_junk);
        sb_q.push_back(model(q));
        exp_done++;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("out_valid_cleared_by_start", longint'(bus.out_valid), 0);
        check("busy_in_acc", longint'(bus.busy), 1);
        for (int s = 0; s < 4; s++) begin
            bus.in_valid = 1'b1;
            bus.start = start_mid && (s == 2);
            drive(q[s]);
            @(negedge clk);
            if (s == 3) last_acc_cyc = cyc;
            bus.in_valid = 1'b0;
            bus.start = 1'b0;
            repeat (gap) @(negedge clk);
        end
        if (drain_junk) begin
            bus.in_valid = 1'b1;
            drive(mk(1048576, 1048576, 1048576, 1048576, 65536, 65536, 65536, 65536));
            repeat (3) @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt < exp_done && t < 40) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done_seen"}, longint'(done_cnt >= exp_done), 1);
    endtask

    task automatic post_check(input string name, input longint h_ezg0, input longint h_egp0);
        check({name, "_out_valid"}, longint'(bus.out_valid), 1);
        check({name, "_busy"}, longint'(bus.busy), 0);
        check({name, "_ezg0"}, ezg_w(0), h_ezg0);
        check({name, "_egp0"}, egp_w(0), h_egp0);
    endtask

    initial begin
        samp_t q[4];
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));

        vecs[0] = '{mk(65536, 65536, 65536, 65536, 65536, 0, 0, 0), 65536, 196608};
        vecs[1] = '{mk(131072, 131072, 131072, 131072, 32768, 32768, 32768, 32768),
                    262144, 786432};
        vecs[2] = '{mk(1048576, 0, 0, 0, 65536, 0, 0, 0), 33554431, 33554431};
        vecs[3] = '{mk(-65536, -65536, -65536, -65536, 65536, 65536, 65536, 65536),
                    -65536, 196608};
        vecs[4] = '{mk(32768, 32768, 32768, 32768, -131072, -131072, -131072, -131072),
                    -16384, 49152};
        vecs[5] = '{mk(-1048576, 0, 0, 0, 65536, 0, 0, 0), -33554432, 33554431};

        repeat (2) @(negedge clk);
        check("reset_busy", longint'(bus.busy), 0);
        check("reset_out_valid", longint'(bus.out_valid), 0);
        check("reset_done", longint'(bus.done), 0);
        check("reset_ezg_zero", longint'(bus.ezg_flat != '0), 0);
        check("reset_egp_zero", longint'(bus.egp_flat != '0), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            for (int s = 0; s < 4; s++) q[s] = vecs[v].s;
            run_batch(q, 0, 1'b0, 1'b0);
            wait_done($sformatf("vec%0d", v));
            post_check($sformatf("vec%0d", v), vecs[v].hand_ezg0, vecs[v].hand_egp0);
        end

        // Results hold across idle cycles until the next start.
        repeat (6) @(negedge clk);
        post_check("hold", vecs[5].hand_ezg0, vecs[5].hand_egp0);

        // Alternating sign with two idle cycles between samples.
        q[0] = mk(65536, 0, 0, 0, 65536, 0, 0, 0);
        q[1] = mk(-65536, 0, 0, 0, 65536, 0, 0, 0);
        q[2] = q[0];
        q[3] = q[1];
        run_batch(q, 2, 1'b0, 1'b0);
        wait_done("alt");
        post_check("alt", 0, 196608);

        // Abort after two samples: no done, outputs cleared.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            bus.in_valid = 1'b1;
            drive(vecs[0].s);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("abort_busy_before", longint'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_out_valid", longint'(bus.out_valid), 0);
        check("abort_ezg_zero", longint'(bus.ezg_flat != '0), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_done", longint'(done_cnt), longint'(exp_done));
        check("abort_idle_out_valid", longint'(bus.out_valid), 0);
        for (int s = 0; s < 4; s++) q[s] = vecs[0].s;
        run_batch(q, 0, 1'b0, 1'b0);
        wait_done("after_abort");
        post_check("after_abort", vecs[0].hand_ezg0, vecs[0].hand_egp0);

        // Start during ACC and in_valid during DRAIN are ignored.
        run_batch(q, 0, 1'b1, 1'b1);
        wait_done("ignored_ctl");
        post_check("ignored_ctl", vecs[0].hand_ezg0, vecs[0].hand_egp0);
        repeat (10) @(negedge clk);
        check("no_extra_done", longint'(done_cnt), longint'(exp_done));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
